// File: rtl/cae_disp_pkg.sv
// Shared types and constants for the Convey dispatch controller:
// FSM state encoding, exception bit positions and AEG index helpers.
package cae_disp_pkg;

    localparam int AEG_IDX_W     = 18;
    localparam int DATA_W        = 64;
    localparam int EXC_W         = 16;
    localparam int RES_IDX_W     = 8;

    localparam int EXC_UNIMPL    = 0;
    localparam int EXC_AEG_RANGE = 1;
    localparam int EXC_BUSY      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_e;

    function automatic logic aeg_in_range(input logic [AEG_IDX_W-1:0] idx, input int num_aeg);
        return (idx < AEG_IDX_W'(num_aeg));
    endfunction

endpackage

// File: rtl/cae_aeg_file.sv
// AEG register file: NUM_AEG x 64-bit registers with three prioritised write
// ports (counter, dispatch, core result), one registered read port, flat view.
module cae_aeg_file
    import cae_disp_pkg::*;
#(
    parameter int NUM_AEG = 16
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cnt_wr_en,
    input  logic [DATA_W-1:0]         cnt_wr_data,
    input  logic                      dsp_wr_en,
    input  logic [AEG_IDX_W-1:0]      dsp_wr_idx,
    input  logic [DATA_W-1:0]         dsp_wr_data,
    input  logic                      res_wr_en,
    input  logic [RES_IDX_W-1:0]      res_wr_idx,
    input  logic [DATA_W-1:0]         res_wr_data,
    input  logic                      rd_en,
    input  logic [AEG_IDX_W-1:0]      rd_idx,
    output logic                      rd_vld,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_AEG*DATA_W-1:0] core_aeg
);

    localparam int SEL_W = (NUM_AEG > 1) ? $clog2(NUM_AEG) : 1;

    logic [DATA_W-1:0] aeg_r [NUM_AEG];
    logic              dsp_ok_s;
    logic              res_ok_s;
    logic              rd_ok_s;

    // Qualify each access with its index range; out-of-range accesses do nothing.
    always_comb begin
        dsp_ok_s = dsp_wr_en && aeg_in_range(dsp_wr_idx, NUM_AEG);
        res_ok_s = res_wr_en && ({1'b0, res_wr_idx} < 9'(NUM_AEG));
        rd_ok_s  = rd_en && aeg_in_range(rd_idx, NUM_AEG);
    end

    // Register writes; the counter owns the last AEG in its cycle, then dispatch, then result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AEG; i++) begin
                aeg_r[i] <= 64'h0;
            end
        end else begin
            for (int i = 0; i < NUM_AEG; i++) begin
                if (cnt_wr_en && (i == NUM_AEG - 1)) begin
                    aeg_r[i] <= cnt_wr_data;
                end else if (dsp_ok_s && (dsp_wr_idx == AEG_IDX_W'(i))) begin
                    aeg_r[i] <= dsp_wr_data;
                end else if (res_ok_s && (res_wr_idx == RES_IDX_W'(i))) begin
                    aeg_r[i] <= res_wr_data;
                end
            end
        end
    end

    // Read port samples the pre-write contents, so a same-cycle write is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld  <= 1'b0;
            rd_data <= 64'h0;
        end else begin
            rd_vld <= rd_en;
            if (rd_ok_s) begin
                rd_data <= aeg_r[rd_idx[SEL_W-1:0]];
            end else begin
                rd_data <= 64'h0;
            end
        end
    end

    // Flatten the register array for the cores, AEG0 in the least significant word.
    always_comb begin
        for (int i = 0; i < NUM_AEG; i++) begin
            core_aeg[i*DATA_W +: DATA_W] = aeg_r[i];
        end
    end

endmodule

// File: rtl/cae_disp_ctrl.sv
// Dispatch controller: decodes dispatched instructions, launches the cores,
// tracks their completion, reports exceptions and times each run.
module cae_disp_ctrl
    import cae_disp_pkg::*;
#(
    parameter int NUM_AEG    = 16,
    parameter int NUM_CORES  = 4,
    parameter int START_INST = 0
)
(
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic                      disp_inst_vld,
    input  logic [4:0]                disp_inst,
    input  logic [AEG_IDX_W-1:0]      disp_aeg_idx,
    input  logic                      disp_aeg_rd,
    input  logic                      disp_aeg_wr,
    input  logic [DATA_W-1:0]         disp_aeg_wr_data,
    output logic [AEG_IDX_W-1:0]      disp_aeg_cnt,
    output logic [EXC_W-1:0]          disp_exception,
    output logic                      disp_idle,
    output logic                      disp_stall,
    output logic                      disp_rtn_data_vld,
    output logic [DATA_W-1:0]         disp_rtn_data,
    output logic [NUM_CORES-1:0]      core_start,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic [NUM_AEG*DATA_W-1:0] core_aeg,
    input  logic                      res_wr_vld,
    input  logic [RES_IDX_W-1:0]      res_wr_idx,
    input  logic [DATA_W-1:0]         res_wr_data
);

    localparam logic [NUM_CORES-1:0] ALL_CORES = {NUM_CORES{1'b1}};
    localparam logic [NUM_CORES-1:0] NO_CORES  = {NUM_CORES{1'b0}};

    disp_state_e          state_r;
    logic [NUM_CORES-1:0] done_mask_r;
    logic [NUM_CORES-1:0] core_start_r;
    logic [DATA_W-1:0]    cycle_cnt_r;
    logic [EXC_W-1:0]     exc_r;

    logic                 is_start_s;
    logic                 all_done_s;
    logic                 cnt_wr_s;
    logic [EXC_W-1:0]     exc_nxt_s;

    // Instruction decode, completion detect and next exception vector.
    always_comb begin
        is_start_s = (disp_inst == 5'(START_INST));
        all_done_s = ((done_mask_r | core_done) == ALL_CORES);
        cnt_wr_s   = (state_r == ST_DONE);

        exc_nxt_s                = 16'h0;
        exc_nxt_s[EXC_UNIMPL]    = disp_inst_vld && (state_r == ST_IDLE) && !is_start_s;
        exc_nxt_s[EXC_AEG_RANGE] = (disp_aeg_rd || disp_aeg_wr) && !aeg_in_range(disp_aeg_idx, NUM_AEG);
        exc_nxt_s[EXC_BUSY]      = disp_inst_vld && (state_r != ST_IDLE);
    end

    // Control FSM with the start pulse, done mask, cycle counter and exception register.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            done_mask_r  <= NO_CORES;
            core_start_r <= NO_CORES;
            cycle_cnt_r  <= 64'h0;
            exc_r        <= 16'h0;
        end else begin
            exc_r        <= exc_nxt_s;
            core_start_r <= NO_CORES;
            case (state_r)
                ST_IDLE: begin
                    if (disp_inst_vld && is_start_s) begin
                        state_r      <= ST_START;
                        done_mask_r  <= NO_CORES;
                        cycle_cnt_r  <= 64'h0;
                        core_start_r <= ALL_CORES;
                    end
                end
                ST_START: begin
                    state_r     <= ST_BUSY;
                    cycle_cnt_r <= cycle_cnt_r + 64'd1;
                end
                ST_BUSY: begin
                    cycle_cnt_r <= cycle_cnt_r + 64'd1;
                    done_mask_r <= done_mask_r | core_done;
                    if (all_done_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    cae_aeg_file #(
        .NUM_AEG (NUM_AEG)
    ) u_aeg_file (
        .clk         (clk),
        .rst         (i_reset),
        .cnt_wr_en   (cnt_wr_s),
        .cnt_wr_data (cycle_cnt_r),
        .dsp_wr_en   (disp_aeg_wr),
        .dsp_wr_idx  (disp_aeg_idx),
        .dsp_wr_data (disp_aeg_wr_data),
        .res_wr_en   (res_wr_vld),
        .res_wr_idx  (res_wr_idx),
        .res_wr_data (res_wr_data),
        .rd_en       (disp_aeg_rd),
        .rd_idx      (disp_aeg_idx),
        .rd_vld      (disp_rtn_data_vld),
        .rd_data     (disp_rtn_data),
        .core_aeg    (core_aeg)
    );

    assign disp_aeg_cnt   = AEG_IDX_W'(NUM_AEG);
    assign disp_idle      = (state_r == ST_IDLE);
    assign disp_stall     = (state_r != ST_IDLE);
    assign disp_exception = exc_r;
    assign core_start     = core_start_r;

endmodule

// File: tb/tb_cae_disp_ctrl.sv
// Directed bench for cae_disp_ctrl: a cycle-level behavioural model is compared
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_cae_disp_ctrl;

    localparam int NA = 16;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            disp_inst_vld;
    logic [4:0]      disp_inst;
    logic [17:0]     disp_aeg_idx;
    logic            disp_aeg_rd;
    logic            disp_aeg_wr;
    logic [63:0]     disp_aeg_wr_data;
    logic [17:0]     disp_aeg_cnt;
    logic [15:0]     disp_exception;
    logic            disp_idle;
    logic            disp_stall;
    logic            disp_rtn_data_vld;
    logic [63:0]     disp_rtn_data;
    logic [NC-1:0]   core_start;
    logic [NC-1:0]   core_done;
    logic [NA*64-1:0] core_aeg;
    logic            res_wr_vld;
    logic [7:0]      res_wr_idx;
    logic [63:0]     res_wr_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_start_pulses = 0;
    bit chk_en = 1'b0;

    // behavioural model state
    logic [63:0] m_aeg [NA];
    bit          m_idle;
    bit          m_launch;
    bit          m_wrap;
    logic [3:0]  m_seen;
    logic [63:0] m_elapsed;
    bit          m_start_req;
    logic        e_vld;
    logic [63:0] e_data;
    logic [15:0] e_exc;
    logic [3:0]  e_start;

    cae_disp_ctrl #(.NUM_AEG(NA), .NUM_CORES(NC), .START_INST(0)) dut (
        .clk               (clk),
        .i_reset           (i_reset),
        .disp_inst_vld     (disp_inst_vld),
        .disp_inst         (disp_inst),
        .disp_aeg_idx      (disp_aeg_idx),
        .disp_aeg_rd       (disp_aeg_rd),
        .disp_aeg_wr       (disp_aeg_wr),
        .disp_aeg_wr_data  (disp_aeg_wr_data),
        .disp_aeg_cnt      (disp_aeg_cnt),
        .disp_exception    (disp_exception),
        .disp_idle         (disp_idle),
        .disp_stall        (disp_stall),
        .disp_rtn_data_vld (disp_rtn_data_vld),
        .disp_rtn_data     (disp_rtn_data),
        .core_start        (core_start),
        .core_done         (core_done),
        .core_aeg          (core_aeg),
        .res_wr_vld        (res_wr_vld),
        .res_wr_idx        (res_wr_idx),
        .res_wr_data       (res_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        disp_inst_vld    = 1'b0;
        disp_inst        = 5'd0;
        disp_aeg_idx     = 18'd0;
        disp_aeg_rd      = 1'b0;
        disp_aeg_wr      = 1'b0;
        disp_aeg_wr_data = 64'h0;
        core_done        = 4'h0;
        res_wr_vld       = 1'b0;
        res_wr_idx       = 8'd0;
        res_wr_data      = 64'h0;
    endtask

    // Model: applies the dispatch rules once per clock, or clears on reset.
    initial forever begin
        @(posedge clk or posedge i_reset);
        if (i_reset) begin
            for (int i = 0; i < NA; i++) m_aeg[i] = 64'h0;
            m_idle = 1'b1; m_launch = 1'b0; m_wrap = 1'b0;
            m_seen = 4'h0; m_elapsed = 64'h0;
            e_vld = 1'b0; e_data = 64'h0; e_exc = 16'h0; e_start = 4'h0;
        end else begin
            e_vld  = disp_aeg_rd;
            e_data = (disp_aeg_rd && disp_aeg_idx < 18'd16) ? m_aeg[disp_aeg_idx[3:0]] : 64'h0;
            e_exc  = 16'h0;
            if ((disp_aeg_rd || disp_aeg_wr) && disp_aeg_idx >= 18'd16) e_exc[1] = 1'b1;
            m_start_req = 1'b0;
            if (disp_inst_vld && m_idle) begin
                if (disp_inst == 5'd0) m_start_req = 1'b1;
                else e_exc[0] = 1'b1;
            end
            if (disp_inst_vld && !m_idle) e_exc[2] = 1'b1;
            if (res_wr_vld && res_wr_idx < 8'd16) m_aeg[res_wr_idx[3:0]] = res_wr_data;
            if (disp_aeg_wr && disp_aeg_idx < 18'd16) m_aeg[disp_aeg_idx[3:0]] = disp_aeg_wr_data;
            e_start = 4'h0;
            if (m_wrap) begin
                m_aeg[NA-1] = m_elapsed;
                m_wrap = 1'b0;
                m_idle = 1'b1;
            end else if (m_launch) begin
                m_launch = 1'b0;
                m_elapsed = 64'd1;
                m_seen = 4'h0;
            end else if (!m_idle) begin
                m_elapsed = m_elapsed + 64'd1;
                m_seen = m_seen | core_done;
                if (m_seen == 4'hF) m_wrap = 1'b1;
            end else if (m_start_req) begin
                m_idle = 1'b0;
                m_launch = 1'b1;
                e_start = 4'hF;
            end
        end
    end

    // Compare: every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (core_start != 4'h0) n_start_pulses++;
        if (chk_en) begin
            chk("idle", {63'h0, disp_idle}, {63'h0, m_idle});
            chk("stall", {63'h0, disp_stall}, {63'h0, !m_idle});
            chk("rtn_vld", {63'h0, disp_rtn_data_vld}, {63'h0, e_vld});
            if (e_vld) chk("rtn_data", disp_rtn_data, e_data);
            chk("exception", {48'h0, disp_exception}, {48'h0, e_exc});
            chk("core_start", {60'h0, core_start}, {60'h0, e_start});
            chk("aeg_cnt", {46'h0, disp_aeg_cnt}, 64'd16);
            for (int i = 0; i < NA; i++) chk("core_aeg", core_aeg[i*64 +: 64], m_aeg[i]);
        end
    end

    initial begin
        clr();
        repeat (3) @(negedge clk);
        #1;
        i_reset = 1'b0;
        chk_en = 1'b1;

        // reset state
        chk("rst_idle", {63'h0, disp_idle}, 64'd1);
        chk("rst_stall", {63'h0, disp_stall}, 64'd0);
        chk("rst_aeg_cnt", {46'h0, disp_aeg_cnt}, 64'd16);
        chk("rst_core_aeg", {63'h0, |core_aeg}, 64'd0);
        chk("rst_exc", {48'h0, disp_exception}, 64'd0);

        // write AEG3 and read it in the same cycle, then read it again
        disp_aeg_wr = 1'b1; disp_aeg_idx = 18'd3; disp_aeg_wr_data = 64'hDEADBEEF; disp_aeg_rd = 1'b1;
        tick(); clr();
        chk("rd_same_cycle_vld", {63'h0, disp_rtn_data_vld}, 64'd1);
        chk("rd_same_cycle_old", disp_rtn_data, 64'h0);
        disp_aeg_rd = 1'b1; disp_aeg_idx = 18'd3;
        tick(); clr();
        chk("rd_after_wr_vld", {63'h0, disp_rtn_data_vld}, 64'd1);
        chk("rd_after_wr_data", disp_rtn_data, 64'hDEADBEEF);
        tick();
        chk("rtn_vld_one_cycle", {63'h0, disp_rtn_data_vld}, 64'd0);

        // start; cores finish 5, 9, 9, 12 cycles after core_start
        disp_inst_vld = 1'b1; disp_inst = 5'd0;
        tick(); clr();
        chk("start_pulse", {60'h0, core_start}, 64'hF);
        chk("start_stall", {63'h0, disp_stall}, 64'd1);
        chk("start_idle", {63'h0, disp_idle}, 64'd0);
        core_done = 4'b1000;
        for (int k = 1; k <= 13; k++) begin
            tick(); clr();
            if (k == 13) begin
                chk("done_not_idle", {63'h0, disp_idle}, 64'd0);
                disp_aeg_wr = 1'b1; disp_aeg_idx = 18'd15; disp_aeg_wr_data = 64'hFFFF;
            end else begin
                core_done[0] = (k == 5) || (k == 7);
                core_done[1] = (k == 9);
                core_done[2] = (k == 9);
                core_done[3] = (k == 12);
                if (k == 2) begin disp_inst_vld = 1'b1; disp_inst = 5'd7; end
                if (k == 3) chk("busy_exc", {48'h0, disp_exception}, 64'h4);
                chk("busy_stall", {63'h0, disp_stall}, 64'd1);
            end
        end
        tick(); clr();
        chk("idle_after_done", {63'h0, disp_idle}, 64'd1);
        chk("aeg15_count", core_aeg[15*64 +: 64], 64'd13);
        chk("model_aeg15", m_aeg[15], 64'd13);
        chk("start_pulses", 64'(n_start_pulses), 64'd1);

        // out-of-range read, unimplemented instruction
        disp_aeg_rd = 1'b1; disp_aeg_idx = 18'd20;
        tick(); clr();
        chk("oor_rd_vld", {63'h0, disp_rtn_data_vld}, 64'd1);
        chk("oor_rd_data", disp_rtn_data, 64'h0);
        chk("oor_exc", {48'h0, disp_exception}, 64'h2);
        disp_inst_vld = 1'b1; disp_inst = 5'd5;
        tick(); clr();
        chk("unimpl_exc", {48'h0, disp_exception}, 64'h1);
        chk("unimpl_idle", {63'h0, disp_idle}, 64'd1);
        chk("unimpl_no_start", {60'h0, core_start}, 64'h0);
        tick();
        chk("exc_pulse", {48'h0, disp_exception}, 64'h0);

        // write priority and dropped writes
        disp_aeg_wr = 1'b1; disp_aeg_idx = 18'd2; disp_aeg_wr_data = 64'h1111_2222_3333_4444;
        res_wr_vld = 1'b1; res_wr_idx = 8'd2; res_wr_data = 64'h5555;
        tick(); clr();
        chk("aeg2_dispatch_wins", core_aeg[2*64 +: 64], 64'h1111_2222_3333_4444);
        disp_aeg_wr = 1'b1; disp_aeg_idx = 18'd6; disp_aeg_wr_data = 64'hA6;
        res_wr_vld = 1'b1; res_wr_idx = 8'd5; res_wr_data = 64'hB5;
        tick(); clr();
        chk("aeg5_result", core_aeg[5*64 +: 64], 64'hB5);
        chk("aeg6_dispatch", core_aeg[6*64 +: 64], 64'hA6);
        disp_aeg_wr = 1'b1; disp_aeg_idx = 18'd16; disp_aeg_wr_data = 64'h77;
        res_wr_vld = 1'b1; res_wr_idx = 8'd200; res_wr_data = 64'h88;
        tick(); clr();
        chk("oor_wr_exc", {48'h0, disp_exception}, 64'h2);
        chk("aeg3_kept", core_aeg[3*64 +: 64], 64'hDEADBEEF);
        chk("aeg0_kept", core_aeg[0 +: 64], 64'h0);

        // reset mid-BUSY
        disp_inst_vld = 1'b1; disp_inst = 5'd0;
        tick(); clr();
        tick();
        core_done = 4'b0011;
        tick(); clr();
        i_reset = 1'b1;
        #1;
        chk("abort_idle", {63'h0, disp_idle}, 64'd1);
        chk("abort_stall", {63'h0, disp_stall}, 64'd0);
        chk("abort_aeg", {63'h0, |core_aeg}, 64'd0);
        tick();
        i_reset = 1'b0;
        core_done = 4'b1111;
        tick(); clr();
        chk("late_done_idle", {63'h0, disp_idle}, 64'd1);
        chk("late_done_no_start", {60'h0, core_start}, 64'h0);
        tick(); tick();
        chk("late_done_no_cnt", core_aeg[15*64 +: 64], 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
